// File: rtl/scan_ff_chain.sv
// scan_ff_chain: WIDTH-bit, DEPTH-stage scannable register pipeline.
//
// The pipeline carries A to K with a latency of exactly DEPTH clock edges.
// All WIDTH*DEPTH flops are also stitched into one serial scan chain:
//   scan_in -> stage[0][0] -> ... -> stage[0][WIDTH-1] -> stage[1][0] -> ...
//           -> stage[DEPTH-1][WIDTH-1] -> scan_out
// The chain can be shifted manually (scan_en), or a start pulse runs an
// automatic sequence: L shift cycles followed by one functional capture.
//
// Per-cycle update priority:
//   reset > controller (start cycle / SHIFT / CAPTURE) > scan_en > hold > functional
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous, active-low reset
//   A         functional data in (WIDTH bits)
//   K         functional data out, stage[DEPTH-1] (registered)
//   hold      functional stall, all stages keep their value
//   scan_en   manual scan shift, one bit per cycle
//   scan_in   serial scan data in
//   scan_out  serial scan data out, stage[DEPTH-1][WIDTH-1] (registered)
//   start     single-cycle request for an automatic load+capture sequence
//   busy      high while the controller is in SHIFT or CAPTURE (registered)
//   done      one-cycle pulse when the sequence completes (registered)

module scan_ff_chain #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] K,
    input  logic             hold,
    input  logic             scan_en,
    input  logic             scan_in,
    output logic             scan_out,
    input  logic             start,
    output logic             busy,
    output logic             done
);

    localparam int unsigned L     = WIDTH * DEPTH;
    localparam int unsigned CNT_W = $clog2(L + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    // Data-path operation chosen for the current cycle.
    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_SHIFT = 2'd1,
        OP_FUNC  = 2'd2
    } op_t;

    state_t                      state_q;
    state_t                      state_d;
    logic [CNT_W-1:0]            count_q;
    logic [CNT_W-1:0]            count_d;
    logic                        busy_d;
    logic                        done_d;
    op_t                         op;

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;
    logic [DEPTH-1:0][WIDTH-1:0] stage_func;
    logic [L-1:0]                chain_q;
    logic [L-1:0]                chain_shift;

    // Flattened chain view: bit i*WIDTH+b is stage[i][b], so bit 0 sits next
    // to scan_in and bit L-1 drives scan_out.
    assign chain_q = stage_q;

    // Serial shift: every bit moves one position toward scan_out.
    assign chain_shift[0] = scan_in;
    for (genvar j = 1; j < L; j++) begin : g_shift
        assign chain_shift[j] = chain_q[j-1];
    end

    // Functional step: A enters stage 0, every stage advances by one.
    assign stage_func[0] = A;
    for (genvar i = 1; i < DEPTH; i++) begin : g_func
        assign stage_func[i] = stage_q[i-1];
    end

    // Controller state register, including registered busy/done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Controller next-state and data-path operation select.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
        op      = OP_HOLD;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // The chain holds in the start cycle, even over scan_en.
                    state_d = SHIFT;
                    count_d = '0;
                    op      = OP_HOLD;
                end else if (scan_en) begin
                    op = OP_SHIFT;
                end else if (hold) begin
                    op = OP_HOLD;
                end else begin
                    op = OP_FUNC;
                end
            end

            SHIFT: begin
                op      = OP_SHIFT;
                count_d = count_q + CNT_W'(1);
                // This cycle performs shift number count_q+1; the L-th ends SHIFT.
                if (count_q == CNT_W'(L - 1)) begin
                    state_d = CAPTURE;
                end
            end

            CAPTURE: begin
                op      = OP_FUNC;
                state_d = IDLE;
                done_d  = 1'b1;
            end

            default: begin
                state_d = IDLE;
                op      = OP_HOLD;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Next pipeline/chain contents from the selected operation.
    always_comb begin
        stage_d = stage_q;
        case (op)
            OP_SHIFT: stage_d = chain_shift;
            OP_FUNC:  stage_d = stage_func;
            default:  stage_d = stage_q;
        endcase
    end

    // Pipeline / scan flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign K        = stage_q[DEPTH-1];
    assign scan_out = stage_q[DEPTH-1][WIDTH-1];

endmodule
